subtract_multi: RTL and testbench
=================================

Name: subtract_multi

Overview:
- Parametrised, pipelined successor of the background-subtraction stage in the motion-detection pipeline.
- Pops one background pixel and one frame pixel per cycle from their FIFOs.
- Computes per-channel absolute differences and applies a run-time threshold with a selectable decision mode.
- Pushes a binary mask pixel (all-ones = motion, zero = static) to the output FIFO at full throughput, and reports a per-frame motion-pixel count.

Parameters:
- CH_W, 8, bits per colour channel
- N_CH, 3, channels per pixel; pixel width PIX_W = N_CH*CH_W
- FRAME_PIXELS, 388800, pixels per frame (720x540); localparam CNT_W = $clog2(FRAME_PIXELS+1)

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- threshold  in  CH_W  motion threshold; motion when diff > threshold
- mode  in  2  decision mode (motion_mode_t)
- bg_rd_en  out  1  background FIFO pop
- bg_empty  in  1  background FIFO empty
- bg_dout  in  PIX_W  background pixel, channel 0 in bits [CH_W-1:0]
- fr_rd_en  out  1  frame FIFO pop
- fr_empty  in  1  frame FIFO empty
- fr_dout  in  PIX_W  current frame pixel
- out_wr_en  out  1  output FIFO push
- out_full  in  1  output FIFO full
- out_din  out  PIX_W  mask pixel
- motion_count  out  CNT_W  motion pixels in last completed frame
- frame_done  out  1  one-cycle pulse on final pixel push of a frame

Behaviour:
- Reset (reset_n low, asynchronous): s1_v=0, s2_v=0, pixel and motion accumulators=0, motion_count=0, frame_done=0, latched threshold=0, latched mode=MODE_CH0. In-flight pixels are discarded. Outputs are 0 while reset is held.
- Pipeline: stage 1 registers N_CH unsigned abs diffs, each CH_W bits, computed as |fr - bg| with CH_W+1-bit intermediate. Stage 2 registers the mask pixel and the motion bit.
- Handshake, all combinational:
  - adv = !s2_v || !out_full
  - pop = !bg_empty && !fr_empty && (!s1_v || adv)
  - bg_rd_en = fr_rd_en = pop; both FIFOs are always popped together, never one alone.
  - out_wr_en = s2_v && !out_full; out_din = stage-2 data, or 0 when s2_v=0.
- Stage updates:
  - When adv: s2 <= s1 and s2_v <= s1_v.
  - When pop: s1 loads new diffs, s1_v <= 1.
  - Else if adv: s1_v <= 0.
- Latency: pop in cycle t gives out_wr_en in cycle t+2 at the earliest. Throughput is 1 pixel/cycle with no bubbles while inputs are non-empty and output is not full.
- Backpressure: out_full holds both stages, and no pop occurs when s1 is occupied. No data loss or duplication. An out_full deassert allows a push in the same cycle.
- Threshold/mode latching: sampled into internal registers on the pop of the first pixel of a frame (pixel accumulator == 0). Held constant for the whole frame; mid-frame changes take effect next frame.
- Decision modes (d_i = channel diff):
  - MODE_CH0 = 0: d_0 > thr. Legacy single-channel behaviour.
  - MODE_ANY = 1: any d_i > thr.
  - MODE_ALL = 2: every d_i > thr.
  - MODE_SUM = 3: sum of d_i > N_CH*thr. Width CH_W+$clog2(N_CH)+1, no overflow.
- Mask: motion -> all PIX_W bits 1; otherwise 0.
- Counters, advanced on each out_wr_en:
  - pixel accumulator +1; motion accumulator +motion bit.
  - When pixel accumulator == FRAME_PIXELS-1 at a push:
    - frame_done=1 that cycle (registered, visible the following cycle).
    - motion_count <= motion accumulator + motion bit.
    - Both accumulators clear to 0.
- motion_count holds its value between frames. The motion accumulator never exceeds FRAME_PIXELS, so no saturation is needed.
- Equal diff and threshold is not motion. Threshold 0 with identical pixels gives no motion. Threshold 2^CH_W-1 gives no motion in any mode.

Decomposition:
- Package motion_pkg:
  - typedef enum logic [1:0] motion_mode_t {MODE_CH0, MODE_ANY, MODE_ALL, MODE_SUM}
  - default CH_W and N_CH constants
  - MASK_ON/MASK_OFF helpers
- Sub-module chan_absdiff: combinational, one CH_W channel pair -> abs diff. Instantiated N_CH times via generate.

Test Plan:
- Reset mid-stream: assert reset_n=0 with s1_v=s2_v=1 -> next cycle out_wr_en=0, motion_count=0, no pop until reset_n=1 and FIFOs non-empty.
- MODE_CH0, thr=50: fr=0x000040 vs bg=0x00000E (diff 50) -> out_din=0x000000; fr=0x000041 (diff 51) -> 0xFFFFFF, exactly 2 cycles after pop.
- MODE_ANY vs MODE_ALL, thr=10: fr=0x1400FF, bg=0x000000 -> ANY gives 0xFFFFFF, ALL gives 0x000000 (ch1 diff 0). bg > fr case 0x00, 0x05 diff 5 -> no motion.
- Back-to-back throughput: 16 pixel pairs always available, out_full=0 -> 16 consecutive pop cycles, 16 consecutive pushes in matching order.
- Backpressure: out_full=1 for 5 cycles mid-stream -> at most 2 pops during stall, no output change, all pixels delivered once in order after release.
- Frame boundary, FRAME_PIXELS=8 override, 3 motion pixels, thr changed 20->40 mid-frame -> frame_done pulses once on 8th push, motion_count=3, new thr applied from pixel 0 of next frame.

Source files
------------

// File: rtl/motion_pkg.sv
// Shared types and constants for the motion-detection subtraction stage.
package motion_pkg;

  typedef enum logic [1:0] {
    MODE_CH0 = 2'd0,
    MODE_ANY = 2'd1,
    MODE_ALL = 2'd2,
    MODE_SUM = 2'd3
  } motion_mode_t;

  localparam int unsigned DEF_CH_W = 8;
  localparam int unsigned DEF_N_CH = 3;

  localparam logic MASK_ON  = 1'b1;
  localparam logic MASK_OFF = 1'b0;

  function automatic logic mask_bit(input logic motion);
    return motion ? MASK_ON : MASK_OFF;
  endfunction

endpackage

// File: rtl/chan_absdiff.sv
// Unsigned absolute difference of one colour channel pair.
module chan_absdiff #(
  parameter int unsigned CH_W = 8
) (
  input  logic [CH_W-1:0] fr,
  input  logic [CH_W-1:0] bg,
  output logic [CH_W-1:0] diff
);

  logic [CH_W:0] delta;

  // The extra bit is the borrow: set when bg > fr, then negate.
  assign delta = {1'b0, fr} - {1'b0, bg};
  assign diff  = delta[CH_W] ? CH_W'(-delta) : delta[CH_W-1:0];

endmodule

// File: rtl/subtract_multi.sv
// Two-stage background subtraction: per-channel abs diff, thresholded into a binary mask,
// with a per-frame motion-pixel count.
module subtract_multi
  import motion_pkg::*;
#(
  parameter int unsigned CH_W         = DEF_CH_W,
  parameter int unsigned N_CH         = DEF_N_CH,
  parameter int unsigned FRAME_PIXELS = 388800
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic [CH_W-1:0]                       threshold,
  input  logic [1:0]                            mode,
  output logic                                  bg_rd_en,
  input  logic                                  bg_empty,
  input  logic [N_CH*CH_W-1:0]                  bg_dout,
  output logic                                  fr_rd_en,
  input  logic                                  fr_empty,
  input  logic [N_CH*CH_W-1:0]                  fr_dout,
  output logic                                  out_wr_en,
  input  logic                                  out_full,
  output logic [N_CH*CH_W-1:0]                  out_din,
  output logic [$clog2(FRAME_PIXELS+1)-1:0]     motion_count,
  output logic                                  frame_done
);

  localparam int unsigned PIX_W = N_CH * CH_W;
  localparam int unsigned CNT_W = $clog2(FRAME_PIXELS + 1);
  localparam int unsigned SUM_W = CH_W + $clog2(N_CH) + 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

  logic                       s1_v, s2_v;
  logic [N_CH-1:0][CH_W-1:0]  diff_d, s1_diff;
  logic [PIX_W-1:0]           s2_mask;
  logic                       s2_motion;
  logic [CNT_W-1:0]           pix_acc, mot_acc;
  logic [CH_W-1:0]            thr_q;
  motion_mode_t               mode_q;
  logic                       adv, pop, push, motion_d;
  logic [N_CH-1:0]            gt;
  logic [SUM_W-1:0]           sum, thr_sum;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    chan_absdiff #(.CH_W(CH_W)) u_absdiff (
      .fr   (fr_dout[i*CH_W +: CH_W]),
      .bg   (bg_dout[i*CH_W +: CH_W]),
      .diff (diff_d[i])
    );
  end

  // Pops are suppressed while reset is held so no FIFO data is lost.
  assign adv       = !s2_v || !out_full;
  assign pop       = reset_n && !bg_empty && !fr_empty && (!s1_v || adv);
  assign push      = s2_v && !out_full;
  assign bg_rd_en  = pop;
  assign fr_rd_en  = pop;
  assign out_wr_en = push;
  assign out_din   = s2_v ? s2_mask : '0;

  always_comb begin
    gt       = '0;
    sum      = '0;
    motion_d = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      gt[i] = s1_diff[i] > thr_q;
      sum   = sum + SUM_W'(s1_diff[i]);
    end
    thr_sum = SUM_W'(N_CH) * SUM_W'(thr_q);
    unique case (mode_q)
      MODE_CH0: motion_d = gt[0];
      MODE_ANY: motion_d = |gt;
      MODE_ALL: motion_d = &gt;
      MODE_SUM: motion_d = sum > thr_sum;
      default:  motion_d = gt[0];
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_v         <= 1'b0;
      s2_v         <= 1'b0;
      s1_diff      <= '0;
      s2_mask      <= '0;
      s2_motion    <= 1'b0;
      pix_acc      <= '0;
      mot_acc      <= '0;
      motion_count <= '0;
      frame_done   <= 1'b0;
      thr_q        <= '0;
      mode_q       <= MODE_CH0;
    end else begin
      if (adv) begin
        s2_v      <= s1_v;
        s2_motion <= motion_d;
        s2_mask   <= {PIX_W{mask_bit(motion_d)}};
      end
      if (pop) begin
        s1_v    <= 1'b1;
        s1_diff <= diff_d;
      end else if (adv) begin
        s1_v <= 1'b0;
      end
      // Decision parameters are frozen for a whole frame.
      if (pop && pix_acc == '0) begin
        thr_q  <= threshold;
        mode_q <= motion_mode_t'(mode);
      end
      frame_done <= 1'b0;
      if (push) begin
        if (pix_acc == LAST_PIX) begin
          frame_done   <= 1'b1;
          motion_count <= mot_acc + CNT_W'(s2_motion);
          pix_acc      <= '0;
          mot_acc      <= '0;
        end else begin
          pix_acc <= pix_acc + CNT_W'(1);
          mot_acc <= mot_acc + CNT_W'(s2_motion);
        end
      end
    end
  end

endmodule

// File: tb/tb_subtract_multi.sv
// Self-checking bench: FIFO models, expected-mask scoreboard, vector table and corner sequences.
module tb_subtract_multi;

  localparam int FP = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  threshold = '0;
  logic [1:0]  mode = '0;
  logic        bg_rd_en, fr_rd_en, out_wr_en, frame_done;
  logic        bg_empty = 1'b1, fr_empty = 1'b1, out_full = 1'b0;
  logic [23:0] bg_dout = '0, fr_dout = '0, out_din;
  logic [3:0]  motion_count;

  always #5 clock = ~clock;

  subtract_multi #(.CH_W(8), .N_CH(3), .FRAME_PIXELS(FP)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .threshold    (threshold),
    .mode         (mode),
    .bg_rd_en     (bg_rd_en),
    .bg_empty     (bg_empty),
    .bg_dout      (bg_dout),
    .fr_rd_en     (fr_rd_en),
    .fr_empty     (fr_empty),
    .fr_dout      (fr_dout),
    .out_wr_en    (out_wr_en),
    .out_full     (out_full),
    .out_din      (out_din),
    .motion_count (motion_count),
    .frame_done   (frame_done)
  );

  typedef struct packed {logic [23:0] bg; logic [23:0] fr;} pair_t;
  typedef struct {logic [1:0] mode; int thr; logic [23:0] bg; logic [23:0] fr; logic [23:0] exp;} vec_t;

  pair_t       src_q[$];
  logic [23:0] exp_q[$];
  int n_checks = 0, n_err = 0;
  int cyc = 0, npop = 0, npush = 0, fd_cnt = 0, push_cnt = 0, mot_acc = 0, exp_mc = 0;
  int first_pop = -1, last_pop = 0, first_push = -1, last_push = 0;
  logic [1:0] cur_mode = 0;
  int cur_thr = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [23:0] model(input logic [1:0] m, input int thr, input logic [23:0] bg,
                                        input logic [23:0] fr);
    int a, b, d, sum, ngt, d0;
    logic mot;
    sum = 0; ngt = 0; d0 = 0;
    for (int i = 0; i < 3; i++) begin
      a = int'(fr[i*8 +: 8]);
      b = int'(bg[i*8 +: 8]);
      d = (a > b) ? a - b : b - a;
      if (i == 0) d0 = d;
      sum += d;
      if (d > thr) ngt++;
    end
    case (m)
      2'd0: mot = d0 > thr;
      2'd1: mot = ngt > 0;
      2'd2: mot = ngt == 3;
      default: mot = sum > 3 * thr;
    endcase
    return mot ? 24'hFFFFFF : 24'h000000;
  endfunction

  task automatic send(input logic [23:0] bg, input logic [23:0] fr, input logic [23:0] exp);
    pair_t p;
    p.bg = bg;
    p.fr = fr;
    src_q.push_back(p);
    exp_q.push_back(exp);
  endtask

  task automatic send_model(input logic [23:0] bg, input logic [23:0] fr);
    send(bg, fr, model(cur_mode, cur_thr, bg, fr));
  endtask

  task automatic clear_model();
    src_q.delete();
    exp_q.delete();
    push_cnt = 0; mot_acc = 0; exp_mc = 0; npop = 0; npush = 0; fd_cnt = 0;
    first_pop = -1; first_push = -1;
  endtask

  // Sample at negedge; FIFO pops take effect just after the following posedge.
  always begin
    logic sp, sw, sfd;
    logic [23:0] sd, e;
    logic [3:0] smc;
    @(negedge clock);
    cyc++;
    sp = bg_rd_en; sw = out_wr_en; sd = out_din; sfd = frame_done; smc = motion_count;
    if (bg_rd_en !== fr_rd_en) check("rd_en_pair", 32'(fr_rd_en), 32'(bg_rd_en));
    if (sfd) begin
      fd_cnt++;
      check("fd_boundary", 32'((push_cnt % FP) == 0 && push_cnt > 0), 32'd1);
      check("fd_timing", 32'(last_push), 32'(cyc - 1));
      check("fd_count", 32'(smc), 32'(exp_mc));
    end
    if (sw) begin
      if (exp_q.size() == 0) check("push_unexpected", 32'(sd), 32'hDEAD);
      else begin
        e = exp_q.pop_front();
        check("out_din", 32'(sd), 32'(e));
        push_cnt++;
        if (e == 24'hFFFFFF) mot_acc++;
        if (push_cnt % FP == 0) begin exp_mc = mot_acc; mot_acc = 0; end
      end
      npush++;
      if (first_push < 0) first_push = cyc;
      last_push = cyc;
    end
    @(posedge clock);
    #1;
    if (sp) begin
      if (src_q.size() == 0) check("pop_empty", 32'd1, 32'd0);
      else void'(src_q.pop_front());
      npop++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    bg_empty = src_q.size() == 0;
    fr_empty = bg_empty;
    bg_dout  = bg_empty ? 24'h0 : src_q[0].bg;
    fr_dout  = bg_empty ? 24'h0 : src_q[0].fr;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin step(1); n++; end
    check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    step(3);
  endtask

  task automatic do_reset();
    step(1);
    reset_n  = 1'b0;
    out_full = 1'b0;
    clear_model();
    step(2);
    reset_n = 1'b1;
  endtask

  vec_t vec[14];
  int d1[8] = '{30, 0, 30, 5, 0, 30, 10, 0};
  int d2[8] = '{30, 45, 30, 0, 40, 0, 30, 50};

  initial begin
    int p0;
    logic [23:0] held;
    vec[0]  = '{2'd0, 50,  24'h00000E, 24'h000040, 24'h000000};
    vec[1]  = '{2'd0, 50,  24'h00000E, 24'h000041, 24'hFFFFFF};
    vec[2]  = '{2'd1, 10,  24'h000000, 24'h1400FF, 24'hFFFFFF};
    vec[3]  = '{2'd2, 10,  24'h000000, 24'h1400FF, 24'h000000};
    vec[4]  = '{2'd1, 10,  24'h000005, 24'h000000, 24'h000000};
    vec[5]  = '{2'd1, 10,  24'h0000FF, 24'h000000, 24'hFFFFFF};
    vec[6]  = '{2'd2, 10,  24'h0B0B0B, 24'h000000, 24'hFFFFFF};
    vec[7]  = '{2'd3, 10,  24'h000000, 24'h00001F, 24'hFFFFFF};
    vec[8]  = '{2'd3, 10,  24'h000000, 24'h00001E, 24'h000000};
    vec[9]  = '{2'd0, 0,   24'h123456, 24'h123456, 24'h000000};
    vec[10] = '{2'd1, 255, 24'h000000, 24'hFFFFFF, 24'h000000};
    vec[11] = '{2'd3, 255, 24'h000000, 24'hFFFFFF, 24'h000000};
    vec[12] = '{2'd2, 0,   24'h000000, 24'h010101, 24'hFFFFFF};
    vec[13] = '{2'd3, 200, 24'h000000, 24'hFFFFFF, 24'hFFFFFF};

    do_reset();
    @(negedge clock);
    check("rst_wr", 32'(out_wr_en), 32'd0);
    check("rst_din", 32'(out_din), 32'd0);
    check("rst_mc", 32'(motion_count), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);

    foreach (vec[i]) begin
      do_reset();
      mode = vec[i].mode;
      threshold = 8'(vec[i].thr);
      send(vec[i].bg, vec[i].fr, vec[i].exp);
      wait_drain($sformatf("vec%0d", i));
      check($sformatf("vec%0d_latency", i), 32'(last_push - last_pop), 32'd2);
    end

    // Back-to-back throughput.
    do_reset();
    cur_mode = 2'd1; cur_thr = 10; mode = cur_mode; threshold = 8'(cur_thr);
    for (int i = 0; i < 16; i++) send_model(24'($urandom) & 24'h1F1F1F, 24'($urandom) & 24'h1F1F1F);
    wait_drain("thru");
    check("thru_pops", 32'(npop), 32'd16);
    check("thru_pop_span", 32'(last_pop - first_pop), 32'd15);
    check("thru_push_span", 32'(last_push - first_push), 32'd15);
    check("thru_frames", 32'(fd_cnt), 32'd2);

    // Five-cycle stall mid-stream.
    do_reset();
    cur_mode = 2'd3; cur_thr = 30; mode = cur_mode; threshold = 8'(cur_thr);
    for (int i = 0; i < 12; i++) send_model(24'($urandom) & 24'h3F3F3F, 24'($urandom) & 24'h3F3F3F);
    step(5);
    out_full = 1'b1;
    #1 p0 = npop;
    held = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (i == 0) held = out_din;
      else check("stall_din", 32'(out_din), 32'(held));
      check("stall_wr", 32'(out_wr_en), 32'd0);
    end
    @(posedge clock);
    #2;
    check("stall_pops", 32'((npop - p0) <= 2), 32'd1);
    out_full = 1'b0;
    @(negedge clock);
    check("release_push", 32'(out_wr_en), 32'd1);
    wait_drain("stall");
    check("stall_pushes", 32'(npush), 32'd12);

    // Random backpressure.
    do_reset();
    cur_mode = 2'd2; cur_thr = 5; mode = cur_mode; threshold = 8'(cur_thr);
    for (int i = 0; i < 24; i++) send_model(24'($urandom) & 24'h0F0F0F, 24'($urandom) & 24'h0F0F0F);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
      out_full = 1'($urandom);
      step(1);
    end
    out_full = 1'b0;
    wait_drain("randbp");
    check("randbp_frames", 32'(fd_cnt), 32'd3);

    // Frame boundary with a mid-frame threshold change.
    do_reset();
    cur_mode = 2'd0; cur_thr = 20; mode = cur_mode; threshold = 8'd20;
    for (int i = 0; i < 4; i++) send_model(24'h0, 24'(d1[i]));
    wait_drain("frm1a");
    threshold = 8'd40;
    for (int i = 4; i < 8; i++) send_model(24'h0, 24'(d1[i]));
    wait_drain("frm1b");
    check("frm1_done", 32'(fd_cnt), 32'd1);
    check("frm1_count", 32'(motion_count), 32'd3);
    cur_thr = 40;
    for (int i = 0; i < 8; i++) send_model(24'h0, 24'(d2[i]));
    wait_drain("frm2");
    check("frm2_done", 32'(fd_cnt), 32'd2);
    check("frm2_count", 32'(motion_count), 32'd2);

    // Reset with both stages occupied.
    cur_mode = 2'd1; cur_thr = 0; mode = cur_mode; threshold = 8'd0;
    out_full = 1'b1;
    for (int i = 0; i < 6; i++) send_model(24'h0, 24'($urandom) | 24'h000001);
    step(5);
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("mrst_wr", 32'(out_wr_en), 32'd0);
      check("mrst_pop", 32'(bg_rd_en), 32'd0);
      check("mrst_mc", 32'(motion_count), 32'd0);
      check("mrst_din", 32'(out_din), 32'd0);
    end
    step(1);
    clear_model();
    out_full = 1'b0;
    step(2);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) send_model(24'h0, 24'(i * 7));
    wait_drain("mrst");
    check("mrst_pushes", 32'(npush), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
